// File: rtl/cnu_minsum.sv
// Min-sum check node unit: gathers one row of vtc blocks, tracks min1/min2/idx/sign
// per lane, then replays one ctv block per column in arrival order.
module cnu_minsum #(
   parameter int data_w  = 8,
   parameter int ext_w   = 3,
   parameter int D       = 5,
   parameter int MAX_DEG = 16,
   parameter int col_w   = 4,
   parameter int OFFSET  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic [(data_w+ext_w)*D-1:0]   in_vtc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [col_w-1:0]              out_col,
   output logic [data_w*D-1:0]           out_ctv
);

   localparam int temp_w = data_w + ext_w;
   localparam int mag_w  = temp_w - 1;
   localparam logic [mag_w-1:0] off_v = mag_w'(OFFSET);
   localparam logic [mag_w-1:0] sat_v = mag_w'((1 << (data_w - 1)) - 1);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t             state, state_n;
   logic [col_w-1:0]   col, col_n, k, k_n;
   logic [col_w:0]     deg, deg_n;
   logic [mag_w-1:0]   min1 [D];
   logic [mag_w-1:0]   min1_n [D];
   logic [mag_w-1:0]   min2 [D];
   logic [mag_w-1:0]   min2_n [D];
   logic [col_w-1:0]   idx [D];
   logic [col_w-1:0]   idx_n [D];
   logic [D-1:0]       sign_prod, sign_prod_n;
   logic [D-1:0]       sign_mem [MAX_DEG];
   logic [D-1:0]       sign_mem_n [MAX_DEG];

   logic               out_valid_n, out_last_n;
   logic [col_w-1:0]   out_col_n;
   logic [data_w*D-1:0] out_ctv_n;
   logic [mag_w-1:0]   mag, m_sel, m_off, m_sat;
   logic               sgn;

   assign in_ready = (state == COLLECT);

   // Outputs are computed from the next-state view so they can be registered
   // and still appear the cycle after the last vtc is accepted.
   always_comb begin
      // NOTE: every variable gets its current value first, so no branch can infer a latch.
      state_n     = state;
      col_n       = col;
      deg_n       = deg;
      k_n         = k;
      min1_n      = min1;
      min2_n      = min2;
      idx_n       = idx;
      sign_prod_n = sign_prod;
      sign_mem_n  = sign_mem;
      mag         = '0;
      m_sel       = '0;
      m_off       = '0;
      m_sat       = '0;
      sgn         = 1'b0;
      out_ctv_n   = '0;

      case (state)
         COLLECT: if (in_valid) begin
            for (int i = 0; i < D; i++) begin
               mag = in_vtc[i*temp_w +: mag_w];
               if (mag < min1[i]) begin
                  min2_n[i] = min1[i];
                  min1_n[i] = mag;
                  idx_n[i]  = col;
               end else if (mag < min2[i]) begin
                  min2_n[i] = mag;
               end
               sign_prod_n[i]     = sign_prod[i] ^ in_vtc[i*temp_w + temp_w - 1];
               sign_mem_n[col][i] = in_vtc[i*temp_w + temp_w - 1];
            end
            col_n = col + col_w'(1);
            if (in_last || col == col_w'(MAX_DEG - 1)) begin
               deg_n   = (col_w+1)'(col) + (col_w+1)'(1);
               k_n     = '0;
               state_n = EMIT;
            end
         end
         EMIT: if (out_ready) begin
            if ((col_w+1)'(k) == deg - (col_w+1)'(1)) begin
               state_n     = COLLECT;
               col_n       = '0;
               k_n         = '0;
               sign_prod_n = '0;
               for (int i = 0; i < D; i++) begin
                  min1_n[i] = '1;
                  min2_n[i] = '1;
                  idx_n[i]  = '0;
               end
            end else begin
               k_n = k + col_w'(1);
            end
         end
         default: state_n = COLLECT;
      endcase

      out_valid_n = (state_n == EMIT);
      out_last_n  = out_valid_n && ((col_w+1)'(k_n) == deg_n - (col_w+1)'(1));
      out_col_n   = out_valid_n ? k_n : '0;
      for (int i = 0; i < D; i++) begin
         m_sel = (k_n == idx_n[i]) ? min2_n[i] : min1_n[i];
         m_off = (m_sel > off_v) ? m_sel - off_v : '0;
         m_sat = (m_off > sat_v) ? sat_v : m_off;
         sgn   = (m_sat == '0) ? 1'b0 : (sign_prod_n[i] ^ sign_mem_n[k_n][i]);
         out_ctv_n[i*data_w +: data_w] = out_valid_n ? {sgn, m_sat[data_w-2:0]} : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         col       <= '0;
         deg       <= '0;
         k         <= '0;
         sign_prod <= '0;
         for (int i = 0; i < D; i++) begin
            min1[i] <= '1;
            min2[i] <= '1;
            idx[i]  <= '0;
         end
         // NOTE: sign_mem is a small flop array, so it shares the async reset; a RAM macro would not.
         for (int r = 0; r < MAX_DEG; r++) sign_mem[r] <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_col   <= '0;
         out_ctv   <= '0;
      end else begin
         // NOTE: state registers use <= only; blocking = is reserved for the combinational block.
         state     <= state_n;
         col       <= col_n;
         deg       <= deg_n;
         k         <= k_n;
         sign_prod <= sign_prod_n;
         min1      <= min1_n;
         min2      <= min2_n;
         idx       <= idx_n;
         sign_mem  <= sign_mem_n;
         out_valid <= out_valid_n;
         out_last  <= out_last_n;
         out_col   <= out_col_n;
         out_ctv   <= out_ctv_n;
      end
   end

endmodule

// File: tb/tb_cnu_minsum.sv
// Directed bench for cnu_minsum: rows are driven, a reference min-sum model fills a
// scoreboard, and each ctv block is popped and compared as it leaves the unit.
module tb_cnu_minsum;

   localparam int DW = 8;
   localparam int EW = 3;
   localparam int ND = 5;
   localparam int TW = DW + EW;
   localparam int MW = TW - 1;
   localparam int CW = 4;
   localparam int OFFSET = 0;

   typedef struct {
      logic [CW-1:0]    col;
      logic             last;
      logic [DW*ND-1:0] ctv;
   } exp_t;

   logic               clk, rst_n;
   logic               in_valid, in_ready, in_last;
   logic [TW*ND-1:0]   in_vtc;
   logic               out_valid, out_ready, out_last;
   logic [CW-1:0]      out_col;
   logic [DW*ND-1:0]   out_ctv;

   logic [TW*ND-1:0]   rowbuf [16];
   exp_t               sb [$];
   int                 vectors = 0;
   int                 miscompares = 0;

   cnu_minsum #(.data_w(DW), .ext_w(EW), .D(ND), .MAX_DEG(16), .col_w(CW), .OFFSET(OFFSET)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_vtc(in_vtc),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_col(out_col), .out_ctv(out_ctv)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TW-1:0] lane(input int mag, input bit s);
      return {s, MW'(mag)};
   endfunction

   function automatic void set_lane(input int j, input int i, input int mag, input bit s);
      rowbuf[j][i*TW +: TW] = lane(mag, s);
   endfunction

   function automatic void rand_fill(input int n);
      for (int j = 0; j < n; j++)
         for (int i = 0; i < ND; i++)
            set_lane(j, i, int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
   endfunction

   // Reference: each column gets the min and sign parity over all *other* columns.
   function automatic void model_row(input int n);
      for (int j = 0; j < n; j++) begin
         exp_t e;
         e.col  = CW'(j);
         e.last = (j == n - 1);
         e.ctv  = '0;
         for (int i = 0; i < ND; i++) begin
            int m = 1023;
            bit sg = 1'b0;
            for (int c = 0; c < n; c++) begin
               if (c != j) begin
                  if (int'(rowbuf[c][i*TW +: MW]) < m) m = int'(rowbuf[c][i*TW +: MW]);
                  sg ^= rowbuf[c][i*TW + TW - 1];
               end
            end
            m = (m > OFFSET) ? m - OFFSET : 0;
            if (m > 127) m = 127;
            if (m == 0) sg = 1'b0;
            e.ctv[i*DW +: DW] = {sg, 7'(m)};
         end
         sb.push_back(e);
      end
   endfunction

   // Called at a negedge; returns at the negedge after the block was accepted.
   task automatic send_blk(input logic [TW*ND-1:0] v, input logic last);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_vtc   = v;
      in_last  = last;
      @(negedge clk);
   endtask

   task automatic run_row(input int n, input bit use_last);
      model_row(n);
      for (int j = 0; j < n; j++) send_blk(rowbuf[j], use_last && (j == n - 1));
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("first_ctv_latency", out_valid, 1);
      check("in_ready_in_emit", in_ready, 0);
   endtask

   task automatic drain(input int stall_col, input int stall_len);
      int guard = 0;
      int stalled = 0;
      exp_t e;
      while (sb.size() > 0 && guard < 200) begin
         guard++;
         if (out_valid) begin
            e = sb[0];
            if (int'(out_col) == stall_col && stalled < stall_len) begin
               out_ready = 1'b0;
               in_valid  = 1'b1;
               in_vtc    = {ND{lane(0, 1'b1)}};
               stalled++;
               check("in_ready_stall", in_ready, 0);
            end else begin
               out_ready = 1'b1;
               in_valid  = 1'b0;
               void'(sb.pop_front());
            end
            check("out_col", out_col, e.col);
            check("out_last", out_last, e.last);
            check("out_ctv", out_ctv, e.ctv);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      check("drain_remaining", sb.size(), 0);
      check("in_ready_after_row", in_ready, 1);
      check("out_valid_after_row", out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_vtc = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_col", out_col, 0);
      check("rst_out_ctv", out_ctv, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // Lane0 mags 20,5,9 signs +,-,+ -> 0x85, 0x09, 0x85
      rand_fill(3);
      set_lane(0, 0, 20, 1'b0); set_lane(1, 0, 5, 1'b1); set_lane(2, 0, 9, 1'b0);
      run_row(3, 1'b1);
      drain(-1, 0);

      // Null block in column 1 never becomes min1
      for (int i = 0; i < ND; i++) begin
         set_lane(0, i, 7, 1'b0);
         set_lane(1, i, 1023, 1'b0);
         set_lane(2, i, 12, 1'b0);
      end
      run_row(3, 1'b1);
      drain(-1, 0);

      // Saturation (300/400) and no negative zero (0-/0+)
      rand_fill(2);
      set_lane(0, 0, 300, 1'b0); set_lane(1, 0, 400, 1'b1);
      set_lane(0, 1, 0, 1'b1);   set_lane(1, 1, 0, 1'b0);
      run_row(2, 1'b1);
      drain(-1, 0);

      // Degree-1 row: no other column, magnitude saturates
      rand_fill(1);
      run_row(1, 1'b1);
      drain(-1, 0);

      // Back-pressure on column 2 for 3 cycles, junk vtc offered meanwhile
      rand_fill(6);
      run_row(6, 1'b1);
      drain(2, 3);

      // 16 blocks without in_last force EMIT at degree 16
      rand_fill(16);
      run_row(16, 1'b0);
      drain(-1, 0);

      // Reset mid-EMIT, then a fresh row must not see old mins or signs
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < ND; i++) set_lane(j, i, 1, 1'b1);
      run_row(3, 1'b1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_emit_valid", out_valid, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);
      for (int i = 0; i < ND; i++) begin
         set_lane(0, i, 50 + i, 1'b0);
         set_lane(1, i, 60 + i, 1'b0);
      end
      run_row(2, 1'b1);
      drain(-1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
